// File: rtl/ws_key_pkg.sv
// Shared types and helpers for the debounced push-button input block.
// The channel FSM encoding and the effective debounce counter width live here.
package ws_key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_fsm_t;

  // Simulation builds use a 16-cycle stable period instead of ~21 ms.
  function automatic int cw_eff(input int c_size, input int sim);
    return (sim != 0) ? 4 : c_size;
  endfunction

endpackage

// File: rtl/ws_key_chan.sv
// One push-button channel: two-flop synchroniser, debounce FSM, hold timer.
// All outputs are registered; the raw key input never reaches an output combinationally.
//
// state        | meaning
// -------------+---------------------------------------------------------
// IDLE         | key released and stable
// PRESS_WAIT   | key seen low, waiting for a full stable period
// HELD         | press accepted, timing the hold for the long-press pulse
// RELEASE_WAIT | key seen high, waiting for a full stable period
module ws_key_chan
  import ws_key_pkg::*;
#(
  parameter int CW_EFF    = 4,
  parameter int LONG_SIZE = 4
) (
  input  logic clk_50m,
  input  logic rst_n,
  input  logic key_n,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam logic [CW_EFF-1:0]    CNT_MAX  = '1;
  localparam logic [CW_EFF-1:0]    CNT_ONE  = CW_EFF'(1);
  localparam logic [LONG_SIZE-1:0] LCNT_MAX = '1;
  localparam logic [LONG_SIZE-1:0] LCNT_ONE = LONG_SIZE'(1);
  localparam logic [LONG_SIZE-1:0] LCNT_PRE = LONG_SIZE'((1 << LONG_SIZE) - 2);

  logic [1:0]           sync_q;
  logic                 sync;
  key_fsm_t             state_q, state_d;
  logic [CW_EFF-1:0]    cnt_q, cnt_d;
  logic [LONG_SIZE-1:0] lcnt_q, lcnt_d;
  logic                 kst_q, kst_d;
  logic                 press_q, press_d;
  logic                 rel_q, rel_d;
  logic                 long_q, long_d;

  // Synchroniser resets to the released level so reset never looks like a press.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_n};
    end
  end

  assign sync = sync_q[1];

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lcnt_q  <= '0;
      kst_q   <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lcnt_q  <= lcnt_d;
      kst_q   <= kst_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lcnt_d  = lcnt_q;
    kst_d   = kst_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!sync) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (sync) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HELD;
          kst_d   = 1'b1;
          press_d = 1'b1;
          cnt_d   = '0;
          lcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (sync) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else begin
          // cnt wraps freely; each wrap is one debounce period of hold time.
          cnt_d = cnt_q + CNT_ONE;
          if ((cnt_q == CNT_MAX) && (lcnt_q != LCNT_MAX)) begin
            lcnt_d = lcnt_q + LCNT_ONE;
            long_d = (lcnt_q == LCNT_PRE);
          end
        end
      end
      RELEASE_WAIT: begin
        // lcnt is kept on a bounce back to HELD so the long pulse cannot repeat.
        if (!sync) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          kst_d   = 1'b0;
          rel_d   = 1'b1;
          lcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign key_state   = kst_q;
  assign key_press   = press_q;
  assign key_release = rel_q;
  assign key_long    = long_q;

endmodule

// File: rtl/ws_key_input.sv
// Debounced push-button input block: N_KEYS independent channels plus any_pressed.
// Inputs are active-low buttons asynchronous to clk_50m.
module ws_key_input
  import ws_key_pkg::*;
#(
  parameter int N_KEYS    = 4,
  parameter int C_SIZE    = 20,
  parameter int SIM       = 0,
  parameter int LONG_SIZE = 4
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic              any_pressed
);

  localparam int CW_EFF = cw_eff(C_SIZE, SIM);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    ws_key_chan #(
      .CW_EFF   (CW_EFF),
      .LONG_SIZE(LONG_SIZE)
    ) u_chan (
      .clk_50m    (clk_50m),
      .rst_n      (rst_n),
      .key_n      (key_n[i]),
      .key_state  (key_state[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i])
    );
  end

  assign any_pressed = |key_state;

endmodule

// File: tb/tb_ws_key_input.sv
// Scoreboard bench for ws_key_input (SIM=1): stimulus queues expected pulse events,
// a monitor pops and compares whenever any pulse output is high.
module tb_ws_key_input;

  logic       clk_50m;
  logic       rst_n;
  logic [3:0] key_n;
  logic [3:0] key_state, key_press, key_release, key_long;
  logic       any_pressed;

  int checks;
  int errors;
  int cyc;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] lng;
    logic [3:0] st;
  } exp_t;

  exp_t exp_q[$];

  ws_key_input #(
    .N_KEYS   (4),
    .C_SIZE   (20),
    .SIM      (1),
    .LONG_SIZE(4)
  ) dut (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .key_n      (key_n),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .any_pressed(any_pressed)
  );

  initial clk_50m = 1'b0;
  always #5 clk_50m = ~clk_50m;

  initial cyc = 0;
  always @(posedge clk_50m) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_50m);
  endtask

  // Called at a negedge right after key_n changes: the next posedge is e0.
  task automatic expect_evt(input int dly, input logic [3:0] p, input logic [3:0] r,
                            input logic [3:0] l, input logic [3:0] s);
    exp_t e;
    e.cyc   = cyc + 1 + dly;
    e.press = p;
    e.rel   = r;
    e.lng   = l;
    e.st    = s;
    exp_q.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"},   {28'd0, key_state},   32'd0);
    chk({tag, "_press"},   {28'd0, key_press},   32'd0);
    chk({tag, "_release"}, {28'd0, key_release}, 32'd0);
    chk({tag, "_long"},    {28'd0, key_long},    32'd0);
    chk({tag, "_any"},     {31'd0, any_pressed}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    key_n  = 4'hF;

    fork
      forever begin
        @(negedge clk_50m);
        chk_overlap: if ((key_press & key_release) != 4'h0)
          chk("press_release_overlap", {28'd0, key_press & key_release}, 32'd0);
        if ((key_press | key_release | key_long) != 4'h0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse", {16'd0, key_press, key_release, key_long, key_state}, 32'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("evt_cycle",   cyc, e.cyc);
            chk("evt_press",   {28'd0, key_press},   {28'd0, e.press});
            chk("evt_release", {28'd0, key_release}, {28'd0, e.rel});
            chk("evt_long",    {28'd0, key_long},    {28'd0, e.lng});
            chk("evt_state",   {28'd0, key_state},   {28'd0, e.st});
            chk("evt_any",     {31'd0, any_pressed}, {31'd0, (e.st != 4'h0)});
          end
        end
      end
    join_none

    wait_cyc(4);
    chk_all_zero("reset");
    rst_n = 1'b1;
    wait_cyc(3);

    // 1: clean press on key 0
    key_n[0] = 1'b0;
    expect_evt(18, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    wait_cyc(100);
    chk("t1_state", {28'd0, key_state}, 32'h1);
    chk("t1_any", {31'd0, any_pressed}, 32'h1);

    // 3: release key 0
    key_n[0] = 1'b1;
    expect_evt(18, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    wait_cyc(30);

    // 2: bounce on key 1, then a clean press and release
    key_n[1] = 1'b0;
    wait_cyc(10);
    key_n[1] = 1'b1;
    wait_cyc(3);
    key_n[1] = 1'b0;
    expect_evt(18, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    wait_cyc(30);
    key_n[1] = 1'b1;
    expect_evt(18, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    wait_cyc(25);

    // 4: long press on key 2
    key_n[2] = 1'b0;
    expect_evt(18, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    expect_evt(18 + 240, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    wait_cyc(300);
    key_n[2] = 1'b1;
    expect_evt(18, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    wait_cyc(25);

    // 5: reset during PRESS_WAIT, then during HELD, with key 3 held throughout
    key_n[3] = 1'b0;
    wait_cyc(8);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_pw");
    wait_cyc(3);
    rst_n = 1'b1;
    expect_evt(18, 4'b1000, 4'b0000, 4'b0000, 4'b1000);
    wait_cyc(30);
    chk("t5_held_state", {28'd0, key_state}, 32'h8);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_held");
    wait_cyc(3);
    rst_n = 1'b1;
    expect_evt(18, 4'b1000, 4'b0000, 4'b0000, 4'b1000);
    wait_cyc(30);
    key_n[3] = 1'b1;
    expect_evt(18, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
    wait_cyc(25);

    // 6: simultaneous press on keys 0 and 3, staggered release
    key_n = 4'b0110;
    expect_evt(18, 4'b1001, 4'b0000, 4'b0000, 4'b1001);
    wait_cyc(30);
    key_n[0] = 1'b1;
    expect_evt(18, 4'b0000, 4'b0001, 4'b0000, 4'b1000);
    wait_cyc(25);
    chk("t6_any_key3", {31'd0, any_pressed}, 32'h1);
    key_n[3] = 1'b1;
    expect_evt(18, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
    wait_cyc(25);
    chk("t6_any_none", {31'd0, any_pressed}, 32'h0);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
